// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: stage stall/exception requests in, stall vector and PC redirect out.
// The master side is the pipeline datapath; the slave side is pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int N_INST_ADDR = 32
);
  logic                   i_stallreq_id;
  logic                   i_stallreq_ex;
  logic                   i_except_valid;
  logic [31:0]            i_except_type;
  logic [N_INST_ADDR-1:0] i_cp0_epc;
  logic [5:0]             o_stall;
  logic                   o_flush;
  logic [N_INST_ADDR-1:0] o_new_pc;
  logic                   o_new_pc_valid;
  logic                   o_stall_timeout;
  logic [31:0]            o_stall_cycles;
  logic [15:0]            o_flush_count;

  modport master (
    output i_stallreq_id, i_stallreq_ex, i_except_valid, i_except_type, i_cp0_epc,
    input  o_stall, o_flush, o_new_pc, o_new_pc_valid, o_stall_timeout,
           o_stall_cycles, o_flush_count
  );

  modport slave (
    input  i_stallreq_id, i_stallreq_ex, i_except_valid, i_except_type, i_cp0_epc,
    output o_stall, o_flush, o_new_pc, o_new_pc_valid, o_stall_timeout,
           o_stall_cycles, o_flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stall requests into the 6-bit stall bus, sequences exception flush/redirect.
// o_stall is combinational; flush/redirect appear one cycle after the exception edge.
module pipe_ctrl #(
  parameter int                      N_INST_ADDR  = 32,
  parameter logic [N_INST_ADDR-1:0]  EXC_VECTOR   = 32'h0000_0040,
  parameter logic [N_INST_ADDR-1:0]  INT_VECTOR   = 32'h0000_0020,
  parameter int                      FLUSH_CYCLES = 2,
  parameter int                      STALL_LIMIT  = 1024
) (
  input logic        i_clk,
  input logic        i_rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {IDLE, FLUSH} state_e;

  localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WD_LIMIT   = 16'(STALL_LIMIT);

  state_e                 state_q;
  logic [3:0]             fcnt_q;
  logic                   flush_q;
  logic                   valid_q;
  logic [N_INST_ADDR-1:0] pc_q;
  logic [15:0]            flush_cnt_q;
  logic [15:0]            wd_q;
  logic                   timeout_q;
  logic [31:0]            stall_cyc_q;

  logic [5:0]             stall_d;
  logic [N_INST_ADDR-1:0] pc_d;
  logic [15:0]            wd_d;

  // EX stall also freezes ID and earlier; stall bus is quiet during reset and flush.
  always_comb begin
    stall_d = 6'b000000;
    if (!i_rst && state_q == IDLE) begin
      if (bus.i_stallreq_ex)      stall_d = 6'b001111;
      else if (bus.i_stallreq_id) stall_d = 6'b000111;
    end
  end

  always_comb begin
    pc_d = EXC_VECTOR;
    if (bus.i_except_type == 32'd14)     pc_d = bus.i_cp0_epc;
    else if (bus.i_except_type == 32'd1) pc_d = INT_VECTOR;
  end

  always_comb begin
    wd_d = 16'd0;
    if (stall_d != 6'b000000) wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      fcnt_q      <= 4'd0;
      flush_q     <= 1'b0;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      flush_cnt_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_except_valid) begin
            state_q     <= FLUSH;
            fcnt_q      <= FLUSH_INIT;
            flush_q     <= 1'b1;
            valid_q     <= 1'b1;
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_q + 16'd1;
          end
        end
        FLUSH: begin
          valid_q <= 1'b0;
          if (fcnt_q == 4'd0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            fcnt_q <= fcnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_q        <= 16'd0;
      timeout_q   <= 1'b0;
      stall_cyc_q <= 32'd0;
    end else begin
      wd_q <= wd_d;
      if (wd_d == WD_LIMIT) timeout_q <= 1'b1;
      if (stall_d != 6'b000000) stall_cyc_q <= stall_cyc_q + 32'd1;
    end
  end

  assign bus.o_stall         = stall_d;
  assign bus.o_flush         = flush_q;
  assign bus.o_new_pc        = pc_q;
  assign bus.o_new_pc_valid  = valid_q;
  assign bus.o_stall_timeout = timeout_q;
  assign bus.o_stall_cycles  = stall_cyc_q;
  assign bus.o_flush_count   = flush_cnt_q;

endmodule
